// File: rtl/vga_timing_scaler.sv
// VGA raster engine: programmable timing, integer pixel replication, incremental framebuffer
// addressing with a per-frame base, and sync/blank alignment to a READ_LATENCY pixel memory.
module vga_timing_scaler #(
  parameter int H_BACK       = 24,
  parameter int H_VISIBLE    = 320,
  parameter int H_FRONT      = 8,
  parameter int H_SYNC       = 48,
  parameter int V_BACK       = 35,
  parameter int V_VISIBLE    = 400,
  parameter int V_FRONT      = 12,
  parameter int V_SYNC       = 2,
  parameter int H_SCALE      = 1,
  parameter int V_SCALE      = 2,
  parameter int ADDR_W       = 16,
  parameter int COLOR_W      = 12,
  parameter int READ_LATENCY = 1,
  parameter bit H_SYNC_POL   = 1'b0,
  parameter bit V_SYNC_POL   = 1'b1
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic [ADDR_W-1:0]    read_addr,
  input  logic [COLOR_W-1:0]   read_data,
  output logic [COLOR_W/3-1:0] VGA_R,
  output logic [COLOR_W/3-1:0] VGA_G,
  output logic [COLOR_W/3-1:0] VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 frame_start,
  output logic                 in_vblank
);

  localparam int H_TOT = H_BACK + H_VISIBLE + H_FRONT + H_SYNC;
  localparam int V_TOT = V_BACK + V_VISIBLE + V_FRONT + V_SYNC;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int PIPE  = READ_LATENCY + 2;
  localparam int CW    = COLOR_W / 3;
  localparam int HSW   = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
  localparam int VSW   = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

  localparam logic [HW-1:0]     H_LAST     = HW'(H_TOT - 1);
  localparam logic [HW-1:0]     H_VIS_BEG  = HW'(H_BACK);
  localparam logic [HW-1:0]     H_VIS_END  = HW'(H_BACK + H_VISIBLE);
  localparam logic [HW-1:0]     H_SYNC_BEG = HW'(H_TOT - H_SYNC);
  localparam logic [HW-1:0]     H_ONE      = HW'(1);
  localparam logic [VW-1:0]     V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0]     V_VIS_BEG  = VW'(V_BACK);
  localparam logic [VW-1:0]     V_VIS_END  = VW'(V_BACK + V_VISIBLE);
  localparam logic [VW-1:0]     V_SYNC_BEG = VW'(V_BACK + V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0]     V_ONE      = VW'(1);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(H_VISIBLE / H_SCALE);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [HSW-1:0]    HSUB_LAST  = HSW'(H_SCALE - 1);
  localparam logic [HSW-1:0]    HSUB_ONE   = HSW'(1);
  localparam logic [VSW-1:0]    VSUB_LAST  = VSW'(V_SCALE - 1);
  localparam logic [VSW-1:0]    VSUB_ONE   = VSW'(1);

  if (H_VISIBLE % H_SCALE != 0) begin : g_bad_hscale
    $error("H_SCALE must divide H_VISIBLE");
  end
  if (V_VISIBLE % V_SCALE != 0) begin : g_bad_vscale
    $error("V_SCALE must divide V_VISIBLE");
  end
  if (COLOR_W % 3 != 0) begin : g_bad_color
    $error("COLOR_W must be a multiple of 3");
  end
  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("READ_LATENCY must be at least 1");
  end

  logic [HW-1:0]           h_q, h_d;
  logic [VW-1:0]           v_q, v_d;
  logic [HSW-1:0]          hsub_q, hsub_d;
  logic [VSW-1:0]          vsub_q, vsub_d;
  logic [ADDR_W-1:0]       read_addr_q, read_addr_d;
  logic [ADDR_W-1:0]       line_base_q, line_base_d;
  logic [ADDR_W-1:0]       base_latched_q, base_latched_d;
  logic [PIPE-1:0]         hs_sr_q, hs_sr_d;
  logic [PIPE-1:0]         vs_sr_q, vs_sr_d;
  logic [READ_LATENCY:0]   vis_sr_q, vis_sr_d;
  logic [COLOR_W-1:0]      rgb_q, rgb_d;
  logic                    frame_start_q, frame_start_d;
  logic                    in_vblank_q, in_vblank_d;
  logic                    h_vis, v_vis, vis, hs_level, vs_level;

  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + H_ONE;
    v_d = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + V_ONE;
    end
  end

  assign h_vis    = (h_q >= H_VIS_BEG) && (h_q < H_VIS_END);
  assign v_vis    = (v_q >= V_VIS_BEG) && (v_q < V_VIS_END);
  assign vis      = h_vis && v_vis;
  assign hs_level = (h_q >= H_SYNC_BEG) ? H_SYNC_POL : ~H_SYNC_POL;
  assign vs_level = (v_q >= V_SYNC_BEG) ? V_SYNC_POL : ~V_SYNC_POL;

  // Pixel address: reload from line_base at the first visible clock, then step every H_SCALE clocks.
  always_comb begin
    read_addr_d = read_addr_q;
    hsub_d      = hsub_q;
    if (vis) begin
      if (h_q == H_VIS_BEG) begin
        read_addr_d = line_base_q;
        hsub_d      = '0;
      end else if (hsub_q == HSUB_LAST) begin
        read_addr_d = read_addr_q + ADDR_ONE;
        hsub_d      = '0;
      end else begin
        hsub_d = hsub_q + HSUB_ONE;
      end
    end
  end

  // Row base: reloaded throughout line 0, advanced by one fb row after every V_SCALE-th visible line.
  always_comb begin
    line_base_d = line_base_q;
    vsub_d      = vsub_q;
    if (v_q == '0) begin
      line_base_d = base_latched_q;
      vsub_d      = '0;
    end else if (v_vis && (h_q == H_LAST)) begin
      if (vsub_q == VSUB_LAST) begin
        line_base_d = line_base_q + STRIDE;
        vsub_d      = '0;
      end else begin
        vsub_d = vsub_q + VSUB_ONE;
      end
    end
  end

  always_comb begin
    base_latched_d = frame_start_q ? base_addr : base_latched_q;
    frame_start_d  = (h_d == '0) && (v_d == '0);
    in_vblank_d    = !((v_d >= V_VIS_BEG) && (v_d < V_VIS_END));
    hs_sr_d        = {hs_sr_q[PIPE-2:0], hs_level};
    vs_sr_d        = {vs_sr_q[PIPE-2:0], vs_level};
    vis_sr_d       = {vis_sr_q[READ_LATENCY-1:0], vis};
    // vis_sr_q[READ_LATENCY] belongs to the pixel whose data is on read_data this cycle.
    rgb_d          = vis_sr_q[READ_LATENCY] ? read_data : '0;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_q            <= '0;
      v_q            <= '0;
      hsub_q         <= '0;
      vsub_q         <= '0;
      read_addr_q    <= '0;
      line_base_q    <= '0;
      base_latched_q <= '0;
      hs_sr_q        <= {PIPE{~H_SYNC_POL}};
      vs_sr_q        <= {PIPE{~V_SYNC_POL}};
      vis_sr_q       <= '0;
      rgb_q          <= '0;
      frame_start_q  <= 1'b0;
      in_vblank_q    <= 1'b1;
    end else begin
      h_q            <= h_d;
      v_q            <= v_d;
      hsub_q         <= hsub_d;
      vsub_q         <= vsub_d;
      read_addr_q    <= read_addr_d;
      line_base_q    <= line_base_d;
      base_latched_q <= base_latched_d;
      hs_sr_q        <= hs_sr_d;
      vs_sr_q        <= vs_sr_d;
      vis_sr_q       <= vis_sr_d;
      rgb_q          <= rgb_d;
      frame_start_q  <= frame_start_d;
      in_vblank_q    <= in_vblank_d;
    end
  end

  assign read_addr   = read_addr_q;
  assign VGA_R       = rgb_q[CW-1:0];
  assign VGA_G       = rgb_q[2*CW-1:CW];
  assign VGA_B       = rgb_q[3*CW-1:2*CW];
  assign VGA_HS      = hs_sr_q[PIPE-1];
  assign VGA_VS      = vs_sr_q[PIPE-1];
  assign frame_start = frame_start_q;
  assign in_vblank   = in_vblank_q;

endmodule

// File: tb/tb_vga_timing_scaler.sv
// Scoreboard bench for vga_timing_scaler: two small-raster instances (different scale, latency and
// sync polarity) checked every clock against closed-form expected pins.
module tb_vga_timing_scaler;

  localparam int HB = 4, HV = 16, HF = 2, HSY = 3;
  localparam int VB = 3, VV = 8, VF = 1, VSY = 2;
  localparam int H_TOT = HB + HV + HF + HSY;
  localparam int V_TOT = VB + VV + VF + VSY;
  localparam int FRAME = H_TOT * V_TOT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        fs;
    logic        vb;
    logic [15:0] addr;
  } pins_t;

  typedef struct {
    pins_t p;
    int    n;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] base_addr;

  logic [15:0] ra_a, ra_b;
  logic [11:0] rd_a, rd_b, s1_b, s2_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, fs_a, vb_a, hs_b, vs_b, fs_b, vb_b;

  int checks = 0;
  int failures = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic [15:0] base_of_frame [0:15];

  vga_timing_scaler #(
    .H_BACK(HB), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY),
    .V_BACK(VB), .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY),
    .H_SCALE(1), .V_SCALE(2), .ADDR_W(16), .COLOR_W(12), .READ_LATENCY(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
  ) dut_a (
    .vga_clk(clk), .reset(rst), .base_addr(base_addr), .read_addr(ra_a), .read_data(rd_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .frame_start(fs_a), .in_vblank(vb_a)
  );

  vga_timing_scaler #(
    .H_BACK(HB), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY),
    .V_BACK(VB), .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY),
    .H_SCALE(2), .V_SCALE(1), .ADDR_W(16), .COLOR_W(12), .READ_LATENCY(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
  ) dut_b (
    .vga_clk(clk), .reset(rst), .base_addr(base_addr), .read_addr(ra_b), .read_data(rd_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .frame_start(fs_b), .in_vblank(vb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel RAM models: data = addr[11:0], one and three clocks of latency.
  always @(posedge clk) rd_a <= ra_a[11:0];
  always @(posedge clk) begin
    s1_b <= ra_b[11:0];
    s2_b <= s1_b;
    rd_b <= s2_b;
  end

  function automatic bit vis_at(input int m);
    int h = m % H_TOT;
    int v = (m / H_TOT) % V_TOT;
    return (h >= HB) && (h < HB + HV) && (v >= VB) && (v < VB + VV);
  endfunction

  function automatic logic [15:0] addr_of(input int m, input int hsc, input int vsc);
    int h = m % H_TOT;
    int v = (m / H_TOT) % V_TOT;
    int a = int'(base_of_frame[(m / FRAME) % 16]) + ((v - VB) / vsc) * (HV / hsc) + (h - HB) / hsc;
    return a[15:0];
  endfunction

  function automatic pins_t exp_pins(input int n, input int hsc, input int vsc, input int pipe,
                                     input bit hp, input bit vp, input logic [15:0] last);
    pins_t p;
    int vn = (n / H_TOT) % V_TOT;
    p.vb   = !((vn >= VB) && (vn < VB + VV));
    p.fs   = (n > 0) && (n % FRAME == 0);
    p.addr = last;
    p.hs   = ~hp;
    p.vs   = ~vp;
    p.r    = '0;
    p.g    = '0;
    p.b    = '0;
    if (n >= pipe) begin
      int m = n - pipe;
      int h = m % H_TOT;
      int v = (m / H_TOT) % V_TOT;
      logic [15:0] a;
      p.hs = (h >= H_TOT - HSY) ? hp : ~hp;
      p.vs = (v >= VB + VV + VF) ? vp : ~vp;
      if (vis_at(m)) begin
        a   = addr_of(m, hsc, vsc);
        p.r = a[3:0];
        p.g = a[7:4];
        p.b = a[11:8];
      end
    end
    return p;
  endfunction

  // Expected-response generator: n counts clocks since the raster last restarted at (0,0).
  initial begin
    int n = 0;
    logic [15:0] last_a = '0;
    logic [15:0] last_b = '0;
    for (int i = 0; i < 16; i++) base_of_frame[i] = '0;
    forever begin
      @(posedge clk);
      if (!rst) n++;
      #3;
      if (rst) begin
        n = 0;
        last_a = '0;
        last_b = '0;
        for (int i = 0; i < 16; i++) base_of_frame[i] = '0;
      end
      if ((n > 0) && (n % FRAME == 0)) base_of_frame[(n / FRAME) % 16] = base_addr;
      if ((n >= 1) && vis_at(n - 1)) begin
        last_a = addr_of(n - 1, 1, 2);
        last_b = addr_of(n - 1, 2, 1);
      end
      qa.push_back('{p: exp_pins(n, 1, 2, 3, 1'b0, 1'b1, last_a), n: n});
      qb.push_back('{p: exp_pins(n, 2, 1, 5, 1'b1, 1'b0, last_b), n: n});
    end
  end

  task automatic compare(input string name, input exp_t e, input pins_t act);
    checks++;
    if (act !== e.p) begin
      failures++;
      $display("FAIL %s n=%0d got hs=%b vs=%b rgb=%h/%h/%h fs=%b vb=%b addr=%h required hs=%b vs=%b rgb=%h/%h/%h fs=%b vb=%b addr=%h",
               name, e.n, act.hs, act.vs, act.r, act.g, act.b, act.fs, act.vb, act.addr,
               e.p.hs, e.p.vs, e.p.r, e.p.g, e.p.b, e.p.fs, e.p.vb, e.p.addr);
    end
    if (e.p.fs) $display("frame boundary %s n=%0d checks=%0d", name, e.n, checks);
  endtask

  // Monitor: pops one expectation per DUT per clock, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        compare("dut_a", e, {hs_a, vs_a, r_a, g_a, b_a, fs_a, vb_a, ra_a});
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        compare("dut_b", e, {hs_b, vs_b, r_b, g_b, b_b, fs_b, vb_b, ra_b});
      end
    end
  end

  initial begin
    rst = 1'b1;
    base_addr = 16'd0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (100) @(posedge clk);
    #2 base_addr = 16'd1000;
    repeat (400) @(posedge clk);
    #2 base_addr = 16'hFFFF;
    repeat (362) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (800) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
